// File: rtl/cim_drv_pkg.sv
// rtl/cim_drv_pkg.sv - shared state encoding, default geometry and derived widths for the CIM job driver
package cim_drv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        STREAM,
        WAIT,
        RESULT
    } state_t;

    localparam int DEF_NUM_STACKS      = 8;
    localparam int DEF_NUM_INPUTS      = 8;
    localparam int DEF_BIT_WIDTH       = 8;
    localparam int DEF_SRAM_THROUGHPUT = 1;
    localparam int DEF_SCALE_WIDTH     = 4;
    localparam int DEF_SIZE_ACT_ARRAY  = 1;
    localparam int DEF_TIMEOUT_CYCLES  = 256;

    function automatic int out_width(int num_inputs, int bit_width, int scale_width);
        return num_inputs + bit_width - 1 + $clog2(num_inputs) + scale_width;
    endfunction

    function automatic int beat_cnt_width(int num_inputs, int throughput);
        return (num_inputs * throughput > 1) ? $clog2(num_inputs * throughput) : 1;
    endfunction

    // One extra bit so the terminal value TIMEOUT_CYCLES-1 always fits.
    function automatic int timeout_cnt_width(int timeout_cycles);
        return $clog2(timeout_cycles) + 1;
    endfunction

    localparam int DEF_OUT_WIDTH = out_width(DEF_NUM_INPUTS, DEF_BIT_WIDTH, DEF_SCALE_WIDTH);

endpackage

// File: rtl/cim_job_driver_if.sv
// rtl/cim_job_driver_if.sv - host job/result handshakes and CIM array pins seen by the job driver
interface cim_job_driver_if
    import cim_drv_pkg::*;
#(
    parameter int NUM_STACKS            = DEF_NUM_STACKS,
    parameter int STAGE_1_NUM_INPUTS    = DEF_NUM_INPUTS,
    parameter int STAGE_1_BIT_WIDTH     = DEF_BIT_WIDTH,
    parameter int STAGE_4_BIT_WIDTH     = DEF_SCALE_WIDTH,
    parameter int SIZE_ACT_ARRAY        = DEF_SIZE_ACT_ARRAY,
    parameter int STAGE_4_OUT_BIT_WIDTH = out_width(STAGE_1_NUM_INPUTS, STAGE_1_BIT_WIDTH, STAGE_4_BIT_WIDTH)
);
    logic                                                               job_valid;
    logic                                                               job_ready;
    logic [NUM_STACKS-1:0][SIZE_ACT_ARRAY-1:0][STAGE_1_BIT_WIDTH-1:0]     job_act;
    logic [NUM_STACKS-1:0][STAGE_1_NUM_INPUTS-1:0][STAGE_1_BIT_WIDTH-1:0] job_wt;
    logic [STAGE_4_BIT_WIDTH-1:0]                                       job_scale;

    logic                                                               chip_reset;
    logic                                                               wrEn_act_array;
    logic [NUM_STACKS-1:0][SIZE_ACT_ARRAY-1:0][STAGE_1_BIT_WIDTH-1:0]     wrData_act;
    logic                                                               wrEn_queue;
    logic [STAGE_4_BIT_WIDTH-1:0]                                       wrData_queue;
    logic [NUM_STACKS-1:0][STAGE_1_BIT_WIDTH-1:0]                       input_wt;
    logic [NUM_STACKS-1:0]                                              done;
    logic [NUM_STACKS-1:0][STAGE_4_OUT_BIT_WIDTH-1:0]                   stage_4_out;

    logic                                                               res_valid;
    logic                                                               res_ready;
    logic [NUM_STACKS-1:0][STAGE_4_OUT_BIT_WIDTH-1:0]                   res_data;
    logic                                                               res_timeout;

    modport master (
        input  job_valid, job_act, job_wt, job_scale, done, stage_4_out, res_ready,
        output job_ready, chip_reset, wrEn_act_array, wrData_act, wrEn_queue, wrData_queue,
               input_wt, res_valid, res_data, res_timeout
    );

    modport slave (
        output job_valid, job_act, job_wt, job_scale, done, stage_4_out, res_ready,
        input  job_ready, chip_reset, wrEn_act_array, wrData_act, wrEn_queue, wrData_queue,
               input_wt, res_valid, res_data, res_timeout
    );

endinterface

// File: rtl/cim_beat_counter.sv
// rtl/cim_beat_counter.sv - loadable up-counter with terminal-count flag
module cim_beat_counter #(
    parameter int           W        = 3,
    parameter logic [W-1:0] TERMINAL = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == TERMINAL);

endmodule

// File: rtl/cim_job_driver.sv
// rtl/cim_job_driver.sv - sequences one CIM job: clear, load, weight stream, wait for done, return result
module cim_job_driver
    import cim_drv_pkg::*;
#(
    parameter int NUM_STACKS            = DEF_NUM_STACKS,
    parameter int STAGE_1_NUM_INPUTS    = DEF_NUM_INPUTS,
    parameter int STAGE_1_BIT_WIDTH     = DEF_BIT_WIDTH,
    parameter int SRAM_THROUGHPUT       = DEF_SRAM_THROUGHPUT,
    parameter int STAGE_4_BIT_WIDTH     = DEF_SCALE_WIDTH,
    parameter int SIZE_ACT_ARRAY        = DEF_SIZE_ACT_ARRAY,
    parameter int STAGE_4_OUT_BIT_WIDTH = out_width(STAGE_1_NUM_INPUTS, STAGE_1_BIT_WIDTH, STAGE_4_BIT_WIDTH),
    parameter int TIMEOUT_CYCLES        = DEF_TIMEOUT_CYCLES
) (
    input logic               clk,
    input logic               reset,
    cim_job_driver_if.master  bus
);
    localparam int BEATS    = STAGE_1_NUM_INPUTS * SRAM_THROUGHPUT;
    localparam int BEAT_W   = beat_cnt_width(STAGE_1_NUM_INPUTS, SRAM_THROUGHPUT);
    localparam int TMO_W    = timeout_cnt_width(TIMEOUT_CYCLES);
    localparam int WORD_W   = (STAGE_1_NUM_INPUTS > 1) ? $clog2(STAGE_1_NUM_INPUTS) : 1;
    localparam int TP_SHIFT = $clog2(SRAM_THROUGHPUT);

    typedef logic [NUM_STACKS-1:0][SIZE_ACT_ARRAY-1:0][STAGE_1_BIT_WIDTH-1:0]     act_t;
    typedef logic [NUM_STACKS-1:0][STAGE_1_NUM_INPUTS-1:0][STAGE_1_BIT_WIDTH-1:0] wt_t;
    typedef logic [NUM_STACKS-1:0][STAGE_4_OUT_BIT_WIDTH-1:0]                   res_t;

    state_t                       state_q, state_d;
    act_t                         act_q, act_d, wr_act_q, wr_act_d;
    wt_t                          wt_q, wt_d;
    logic [STAGE_4_BIT_WIDTH-1:0] scale_q, scale_d, wr_scale_q, wr_scale_d;
    res_t                         res_data_q, res_data_d;
    logic                         res_timeout_q, res_timeout_d;

    logic [BEAT_W-1:0] beat_cnt;
    logic              beat_tc;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              tmo_tc;
    logic [WORD_W-1:0] word_idx;
    logic              done_all;

    cim_beat_counter #(.W(BEAT_W), .TERMINAL(BEAT_W'(BEATS - 1))) u_beat_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (state_q == LOAD),
        .load_val ('0),
        .en       (state_q == STREAM),
        .cnt      (beat_cnt),
        .tc       (beat_tc)
    );

    // Cleared during STREAM so WAIT cycle k sees count k.
    cim_beat_counter #(.W(TMO_W), .TERMINAL(TMO_W'(TIMEOUT_CYCLES - 1))) u_tmo_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (state_q == STREAM),
        .load_val ('0),
        .en       (state_q == WAIT),
        .cnt      (tmo_cnt),
        .tc       (tmo_tc)
    );

    assign done_all = &bus.done;
    assign word_idx = WORD_W'(beat_cnt >> TP_SHIFT);

    always_comb begin
        state_d       = state_q;
        act_d         = act_q;
        wt_d          = wt_q;
        scale_d       = scale_q;
        wr_act_d      = wr_act_q;
        wr_scale_d    = wr_scale_q;
        res_data_d    = res_data_q;
        res_timeout_d = res_timeout_q;
        unique case (state_q)
            IDLE: begin
                if (bus.job_valid) begin
                    act_d   = bus.job_act;
                    wt_d    = bus.job_wt;
                    scale_d = bus.job_scale;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                // Write data switches to the new job exactly as the strobes rise.
                wr_act_d   = act_q;
                wr_scale_d = scale_q;
                state_d    = LOAD;
            end
            LOAD: state_d = STREAM;
            STREAM: begin
                if (beat_tc) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (done_all || tmo_tc) begin
                    res_data_d    = bus.stage_4_out;
                    res_timeout_d = !done_all;
                    state_d       = RESULT;
                end
            end
            RESULT: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            act_q         <= '0;
            wt_q          <= '0;
            scale_q       <= '0;
            wr_act_q      <= '0;
            wr_scale_q    <= '0;
            res_data_q    <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            act_q         <= act_d;
            wt_q          <= wt_d;
            scale_q       <= scale_d;
            wr_act_q      <= wr_act_d;
            wr_scale_q    <= wr_scale_d;
            res_data_q    <= res_data_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    always_comb begin
        bus.input_wt = '0;
        if (state_q == STREAM) begin
            for (int s = 0; s < NUM_STACKS; s++) begin
                bus.input_wt[s] = wt_q[s][word_idx];
            end
        end
    end

    assign bus.job_ready      = (state_q == IDLE);
    assign bus.chip_reset     = (state_q == CLEAR);
    assign bus.wrEn_act_array = (state_q == LOAD);
    assign bus.wrEn_queue     = (state_q == LOAD);
    assign bus.wrData_act     = wr_act_q;
    assign bus.wrData_queue   = wr_scale_q;
    assign bus.res_valid      = (state_q == RESULT);
    assign bus.res_data       = res_data_q;
    assign bus.res_timeout    = res_timeout_q;

endmodule

// File: tb/tb_cim_job_driver.sv
// tb/tb_cim_job_driver.sv - self-checking bench for cim_job_driver (2 stacks, throughput 1 and 4)
module tb_cim_job_driver;
    import cim_drv_pkg::*;

    localparam int NS    = 2;
    localparam int NI    = 8;
    localparam int TP_A  = 1;
    localparam int TP_B  = 4;
    localparam int TMO   = 256;

    typedef struct {
        logic [NS-1:0][NI-1:0][7:0] wt;
        logic [NS-1:0][0:0][7:0]    act;
        logic [3:0]                 scale;
        int                         done_at;
        logic [NS-1:0]              partial;
        logic [NS-1:0][21:0]        s4;
        int                         hold;
        logic                       exp_tmo;
        int                         exp_wait;
    } vec_t;

    logic clk;
    logic reset;
    int   errs;
    int   checks;
    int   clr_pulses;

    cim_job_driver_if #(.NUM_STACKS(NS)) ifa ();
    cim_job_driver_if #(.NUM_STACKS(NS)) ifb ();

    cim_job_driver #(.NUM_STACKS(NS), .SRAM_THROUGHPUT(TP_A), .TIMEOUT_CYCLES(TMO)) ua (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    cim_job_driver #(.NUM_STACKS(NS), .SRAM_THROUGHPUT(TP_B), .TIMEOUT_CYCLES(TMO)) ub (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (ifa.chip_reset) clr_pulses++;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        v.wt       = {$urandom(), $urandom(), $urandom(), $urandom()};
        v.act      = 16'($urandom());
        v.scale    = 4'($urandom());
        v.s4       = 44'({$urandom(), $urandom()});
        v.done_at  = 0;
        v.partial  = '0;
        v.hold     = 0;
        v.exp_tmo  = 1'b0;
        v.exp_wait = 1;
        return v;
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_ctrl"}, 64'({ifa.job_ready, ifa.chip_reset, ifa.wrEn_act_array, ifa.wrEn_queue,
                                 ifa.res_valid, ifa.res_timeout}), 64'b100000);
        chk({tag, "_wrdata"}, 64'({ifa.wrData_act, ifa.wrData_queue}), 64'd0);
        chk({tag, "_input_wt"}, 64'(ifa.input_wt), 64'd0);
        chk({tag, "_res_data"}, 64'(ifa.res_data), 64'd0);
    endtask

    // Drives one job on instance A and checks the whole timeline; abort_at >= 0 resets mid-stream.
    task automatic do_job(input vec_t v, input int abort_at);
        int            n;
        bit            got;
        logic [NS-1:0][7:0] ew;
        ifa.done = '0;
        @(negedge clk);
        chk("idle_job_ready", 64'(ifa.job_ready), 64'd1);
        ifa.job_wt    = v.wt;
        ifa.job_act   = v.act;
        ifa.job_scale = v.scale;
        ifa.job_valid = 1'b1;
        @(posedge clk);
        #1;
        ifa.job_valid = 1'b0;
        ifa.job_wt    = {$urandom(), $urandom(), $urandom(), $urandom()};
        ifa.job_act   = 16'($urandom());
        ifa.job_scale = 4'($urandom());
        @(negedge clk);
        chk("clear_cycle", 64'({ifa.chip_reset, ifa.wrEn_act_array, ifa.wrEn_queue, ifa.job_ready}), 64'b1000);
        @(negedge clk);
        chk("load_cycle", 64'({ifa.chip_reset, ifa.wrEn_act_array, ifa.wrEn_queue}), 64'b011);
        chk("load_act", 64'(ifa.wrData_act), 64'(v.act));
        chk("load_scale", 64'(ifa.wrData_queue), 64'(v.scale));
        for (int k = 0; k < NI * TP_A; k++) begin
            @(negedge clk);
            for (int s = 0; s < NS; s++) ew[s] = v.wt[s][k / TP_A];
            chk("stream_beat", 64'(ifa.input_wt), 64'(ew));
            if (k == abort_at) begin
                reset = 1'b0;
                #1;
                check_reset_values("abort_reset");
                @(negedge clk);
                reset = 1'b1;
                return;
            end
        end
        n   = 0;
        got = 1'b0;
        for (int j = 0; j < TMO + 40; j++) begin
            @(negedge clk);
            if (ifa.res_valid) begin
                got = 1'b1;
                break;
            end
            n++;
            ifa.done        = (v.done_at >= 0 && j >= v.done_at) ? {NS{1'b1}} : v.partial;
            ifa.stage_4_out = v.s4;
        end
        if (!got) begin
            chk("result_arrives", 64'd0, 64'd1);
            return;
        end
        chk("wait_cycles", 64'(n), 64'(v.exp_wait));
        chk("res_data", 64'(ifa.res_data), 64'(v.s4));
        chk("res_timeout", 64'(ifa.res_timeout), 64'(v.exp_tmo));
        ifa.done = '0;
        for (int h = 0; h < v.hold; h++) begin
            ifa.stage_4_out = 44'({$urandom(), $urandom()});
            @(negedge clk);
            chk("hold_result", 64'({ifa.res_timeout, ifa.res_data}), 64'({v.exp_tmo, v.s4}));
            chk("hold_handshake", 64'({ifa.res_valid, ifa.job_ready}), 64'b10);
        end
        ifa.res_ready = 1'b1;
        @(posedge clk);
        #1;
        ifa.res_ready = 1'b0;
        @(negedge clk);
        chk("after_handshake", 64'({ifa.res_valid, ifa.job_ready}), 64'b01);
    endtask

    task automatic wait_result_a(output int n, output bit got);
        n   = 0;
        got = 1'b0;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            if (ifa.res_valid) begin
                got = 1'b1;
                break;
            end
            n++;
        end
    endtask

    vec_t vt[5];
    vec_t v;
    int   n;
    bit   got;
    logic [NS-1:0][NI-1:0][7:0] wtb;
    logic [NS-1:0][7:0]         ewb;

    initial begin
        errs          = 0;
        checks        = 0;
        clr_pulses    = 0;
        reset         = 1'b0;
        ifa.job_valid = 1'b0;  ifb.job_valid = 1'b0;
        ifa.res_ready = 1'b0;  ifb.res_ready = 1'b0;
        ifa.done      = '0;    ifb.done      = '0;
        ifa.job_wt    = '0;    ifb.job_wt    = '0;
        ifa.job_act   = '0;    ifb.job_act   = '0;
        ifa.job_scale = '0;    ifb.job_scale = '0;
        ifa.stage_4_out = '0;  ifb.stage_4_out = '0;

        // Directed table: stream pattern, zero-delay done, held result, timeout, done on the last WAIT cycle.
        for (int i = 0; i < 5; i++) vt[i] = rand_vec();
        for (int i = 0; i < NI; i++) begin
            vt[0].wt[0][i] = 8'(i + 1);
            vt[0].wt[1][i] = 8'((i + 1) << 4);
        end
        vt[0].done_at = 3;   vt[0].partial = 2'b00; vt[0].exp_wait = 4;   vt[0].exp_tmo = 1'b0;
        vt[1].done_at = 0;   vt[1].partial = 2'b00; vt[1].exp_wait = 1;   vt[1].exp_tmo = 1'b0; vt[1].hold = 10;
        vt[2].done_at = -1;  vt[2].partial = 2'b01; vt[2].exp_wait = 256; vt[2].exp_tmo = 1'b1;
        vt[3].done_at = 5;   vt[3].partial = 2'b10; vt[3].exp_wait = 6;   vt[3].exp_tmo = 1'b0; vt[3].hold = 2;
        vt[4].done_at = 255; vt[4].partial = 2'b01; vt[4].exp_wait = 256; vt[4].exp_tmo = 1'b0;

        #2;
        check_reset_values("reset_state");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) do_job(vt[i], -1);

        // Reset in the middle of STREAM, then a fresh job must start from beat 0.
        do_job(rand_vec(), 3);
        do_job(rand_vec(), -1);

        for (int r = 0; r < 6; r++) begin
            v          = rand_vec();
            v.done_at  = int'($urandom_range(0, 12));
            v.partial  = 2'($urandom_range(0, 2));
            v.hold     = int'($urandom_range(0, 3));
            v.exp_wait = v.done_at + 1;
            v.exp_tmo  = 1'b0;
            do_job(v, -1);
        end

        // Back-to-back with job_valid held high: minimum latency, one CLEAR per job.
        ifa.done        = {NS{1'b1}};
        ifa.stage_4_out = 44'h123_4567_89ab;
        @(negedge clk);
        clr_pulses    = 0;
        ifa.job_wt    = {$urandom(), $urandom(), $urandom(), $urandom()};
        ifa.job_valid = 1'b1;
        @(posedge clk);
        wait_result_a(n, got);
        chk("min_latency", 64'({got, 32'(n)}), 64'({1'b1, 32'd11}));
        ifa.res_ready = 1'b1;
        @(posedge clk);
        #1;
        ifa.res_ready = 1'b0;
        @(negedge clk);
        chk("b2b_ready_after_hs", 64'(ifa.job_ready), 64'd1);
        @(negedge clk);
        chk("b2b_second_clear", 64'(ifa.chip_reset), 64'd1);
        wait_result_a(n, got);
        chk("b2b_second_result", 64'({got, 32'(n)}), 64'({1'b1, 32'd10}));
        ifa.res_ready = 1'b1;
        @(posedge clk);
        #1;
        ifa.res_ready = 1'b0;
        ifa.job_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("b2b_clear_pulses", 64'(clr_pulses), 64'd2);
        ifa.done = '0;

        // Throughput 4 on instance B: each word held 4 cycles, 32 stream cycles.
        for (int s = 0; s < NS; s++)
            for (int i = 0; i < NI; i++) wtb[s][i] = 8'(8'h11 * (i + 1) + s);
        @(negedge clk);
        ifb.job_wt    = wtb;
        ifb.job_valid = 1'b1;
        @(posedge clk);
        #1;
        ifb.job_valid = 1'b0;
        @(negedge clk);
        chk("b_clear", 64'(ifb.chip_reset), 64'd1);
        @(negedge clk);
        chk("b_load", 64'({ifb.wrEn_act_array, ifb.wrEn_queue}), 64'b11);
        for (int k = 0; k < NI * TP_B; k++) begin
            @(negedge clk);
            for (int s = 0; s < NS; s++) ewb[s] = wtb[s][k / TP_B];
            chk("b_stream_beat", 64'(ifb.input_wt), 64'(ewb));
        end
        @(negedge clk);
        chk("b_stream_over", 64'(ifb.input_wt), 64'd0);
        ifb.done        = {NS{1'b1}};
        ifb.stage_4_out = 44'h0ab_cdef_0123;
        got = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (ifb.res_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk("b_result", 64'({got, ifb.res_timeout, ifb.res_data}), 64'({1'b1, 1'b0, 44'h0ab_cdef_0123}));
        ifb.res_ready = 1'b1;
        @(posedge clk);
        #1;
        ifb.res_ready = 1'b0;
        ifb.done      = '0;
        @(negedge clk);
        chk("b_idle", 64'({ifb.res_valid, ifb.job_ready}), 64'b01);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
